// File: rtl/wbregs_target_pkg.sv
// Shared definitions for the wbregs_target housekeeping register window:
// register offsets, window geometry, FSM encoding and a byte-lane helper.
package wbregs_target_pkg;

    localparam int         WIN_SIZE    = 16;
    localparam logic [7:0] ID_DEFAULT  = 8'hA5;

    localparam logic [3:0] OFS_ID      = 4'd0;
    localparam logic [3:0] OFS_SCRATCH = 4'd1;
    localparam logic [3:0] OFS_CTRL    = 4'd2;
    localparam logic [3:0] OFS_EVT     = 4'd3;
    localparam logic [3:0] OFS_UP0     = 4'd4;
    localparam logic [3:0] OFS_UP1     = 4'd5;
    localparam logic [3:0] OFS_UP2     = 4'd6;
    localparam logic [3:0] OFS_UP3     = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_t;

    // Little-endian byte lane select from a 32-bit word.
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wbregs_target_if.sv
// Wishbone classic bus, 16-bit byte address / 8-bit data, as seen by one target.
interface wbregs_target_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wbregs_target_uptime_snap.sv
// Free-running 32-bit uptime counter with clear, plus a shadow copy taken on
// snapshot so a multi-byte read sees one coherent value.
module uptime_snap
    import wbregs_target_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       snap,
    input  logic [1:0] byte_sel,
    output logic [7:0] rd_byte
);

    logic [31:0] cnt_q;
    logic [31:0] shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            // A clear cycle lands on zero without also counting that cycle.
            if (clr) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (snap) begin
                shadow_q <= cnt_q;
            end
        end
    end

    // The snapshotting read returns byte 0 of the value being captured, so it
    // must come from the live counter rather than the not-yet-updated shadow.
    always_comb begin
        if (snap) begin
            rd_byte = cnt_q[7:0];
        end else begin
            rd_byte = get_byte(shadow_q, byte_sel);
        end
    end

endmodule

// File: rtl/wbregs_target.sv
// Wishbone classic target exposing a 16-byte housekeeping window: ID, scratch,
// control output, saturating event counter and an atomically readable uptime.
module wbregs_target
    import wbregs_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADR = 16'h0040,
    parameter logic [7:0]  ID_VALUE = ID_DEFAULT
)
(
    input  logic             clk,
    input  logic             rst,
    wbregs_target_if.slave   wb,
    output logic [7:0]       ctrl_o,
    input  logic             evt_i
);

    wb_state_t  state_q;
    wb_state_t  state_d;

    logic       hit;
    logic       acc;
    logic       wr_acc;
    logic       rd_acc;
    logic [3:0] ofs;

    logic [7:0] scratch_q;
    logic [7:0] ctrl_q;
    logic [7:0] evt_cnt_q;
    logic [7:0] evt_cnt_d;
    logic [7:0] rd_mux;
    logic [7:0] rd_dat_q;
    logic [7:0] up_byte;

    logic       evt_clr;
    logic       up_clr;
    logic       up_snap;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hit    = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[15:4] == BASE_ADR[15:4]);
    assign ofs    = wb.wb_adr_i[3:0];
    // Only an idle target accepts; the cycle that ack is high never re-triggers.
    assign acc    = hit & (state_q == ST_IDLE);
    assign wr_acc = acc & wb.wb_we_i;
    assign rd_acc = acc & ~wb.wb_we_i;

    assign evt_clr = wr_acc & (ofs == OFS_EVT);
    assign up_clr  = wr_acc & (ofs == OFS_UP0);
    assign up_snap = rd_acc & (ofs == OFS_UP0);

    // ---- bus FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- bus FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- bus FSM: outputs ----
    always_comb begin
        wb.wb_ack_o = (state_q == ST_ACK);
        wb.wb_dat_o = (state_q == ST_ACK) ? rd_dat_q : 8'h00;
    end

    // ---- read mux, sampled on the accepting edge ----
    always_comb begin
        rd_mux = 8'h00;
        case (ofs)
            OFS_ID:      rd_mux = ID_VALUE;
            OFS_SCRATCH: rd_mux = scratch_q;
            OFS_CTRL:    rd_mux = ctrl_q;
            OFS_EVT:     rd_mux = evt_cnt_q;
            OFS_UP0, OFS_UP1, OFS_UP2, OFS_UP3: rd_mux = up_byte;
            default:     rd_mux = 8'h00;
        endcase
    end

    // ---- register file ----
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            rd_dat_q  <= '0;
        end else begin
            if (wr_acc && ofs == OFS_SCRATCH) scratch_q <= wb.wb_dat_i;
            if (wr_acc && ofs == OFS_CTRL)    ctrl_q    <= wb.wb_dat_i;
            if (rd_acc)                       rd_dat_q  <= rd_mux;
        end
    end

    assign ctrl_o = ctrl_q;

    // ---- event counter; a clear coinciding with an event counts that event ----
    always_comb begin
        if (evt_clr) begin
            evt_cnt_d = {7'd0, evt_i};
        end else if (evt_i) begin
            evt_cnt_d = sat_inc8(evt_cnt_q);
        end else begin
            evt_cnt_d = evt_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    uptime_snap u_uptime (
        .clk      (clk),
        .rst      (rst),
        .clr      (up_clr),
        .snap     (up_snap),
        .byte_sel (ofs[1:0]),
        .rd_byte  (up_byte)
    );

endmodule

// File: tb/tb_wbregs_target.sv
// Bench for wbregs_target: directed bus scenarios plus randomized traffic,
// checked against a cycle-count based reference model of the register window.
module tb_wbregs_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_i;
    logic [7:0] ctrl_o;

    wbregs_target_if bus ();

    wbregs_target #(
        .BASE_ADR (16'h0040),
        .ID_VALUE (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wb     (bus),
        .ctrl_o (ctrl_o),
        .evt_i  (evt_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: uptime is the number of edges since the last clear edge.
    longint      n_edge = 0;
    longint      up_clr_edge = 0;
    logic [7:0]  m_scratch = 8'h00;
    logic [7:0]  m_ctrl = 8'h00;
    logic [7:0]  m_evt = 8'h00;
    logic [31:0] m_shadow = 32'h0;
    logic [7:0]  exp_rd = 8'h00;
    bit          evt_rand = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] up_before(input longint n);
        return 32'(n - 1 - up_clr_edge);
    endfunction

    task automatic model_edge(input bit r, input bit acc, input bit w,
                              input logic [3:0] o, input logic [7:0] d, input bit e);
        bit clr_evt;
        clr_evt = 1'b0;
        if (r) begin
            m_scratch   = 8'h00;
            m_ctrl      = 8'h00;
            m_evt       = 8'h00;
            m_shadow    = 32'h0;
            up_clr_edge = n_edge;
            return;
        end
        if (acc && !w) begin
            case (o)
                4'd0: exp_rd = 8'hA5;
                4'd1: exp_rd = m_scratch;
                4'd2: exp_rd = m_ctrl;
                4'd3: exp_rd = m_evt;
                4'd4: begin
                    m_shadow = up_before(n_edge);
                    exp_rd   = m_shadow[7:0];
                end
                4'd5: exp_rd = m_shadow[15:8];
                4'd6: exp_rd = m_shadow[23:16];
                4'd7: exp_rd = m_shadow[31:24];
                default: exp_rd = 8'h00;
            endcase
        end
        if (acc && w) begin
            case (o)
                4'd1: m_scratch = d;
                4'd2: m_ctrl = d;
                4'd3: clr_evt = 1'b1;
                4'd4: up_clr_edge = n_edge;
                default: ;
            endcase
        end
        if (clr_evt) m_evt = e ? 8'd1 : 8'd0;
        else if (e && m_evt != 8'hFF) m_evt = m_evt + 8'd1;
    endtask

    // One clock: acc marks the edge on which the bench expects an access to be taken.
    task automatic tick(input bit acc);
        bit r, e, w;
        logic [3:0] o;
        logic [7:0] d;
        if (evt_rand) evt_i = 1'($urandom_range(0, 1));
        r = rst; e = evt_i; w = bus.wb_we_i; o = bus.wb_adr_i[3:0]; d = bus.wb_dat_i;
        @(posedge clk);
        n_edge++;
        model_edge(r, acc, w, o, d, e);
        #1;
    endtask

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic xfer(input bit w, input logic [15:0] a, input logic [7:0] d,
                        input string tag, output logic [7:0] rd);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = w;
        bus.wb_adr_i = a;
        bus.wb_dat_i = d;
        tick(1'b1);
        chk({tag, "_ack"}, bus.wb_ack_o, 1);
        rd = bus.wb_dat_o;
        if (!w) chk({tag, "_dat"}, rd, exp_rd);
        chk({tag, "_ctrl"}, ctrl_o, m_ctrl);
        bus_idle();
        tick(1'b0);
        chk({tag, "_ackfall"}, bus.wb_ack_o, 0);
        chk({tag, "_datzero"}, bus.wb_dat_o, 0);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [15:0] a;
        int          kind;

        rst = 1'b1;
        evt_i = 1'b0;
        bus_idle();
        bus.wb_adr_i = 16'h0;
        bus.wb_dat_i = 8'h0;
        tick(1'b0);
        tick(1'b0);
        chk("rst_ack", bus.wb_ack_o, 0);
        chk("rst_dat", bus.wb_dat_o, 0);
        chk("rst_ctrl", ctrl_o, 0);
        rst = 1'b0;
        tick(1'b0);

        xfer(1'b0, 16'h0040, 8'h00, "id", rd);
        chk("id_val", rd, 8'hA5);
        xfer(1'b0, 16'h0042, 8'h00, "ctrl0", rd);
        chk("ctrl0_val", rd, 8'h00);

        xfer(1'b1, 16'h0041, 8'h5A, "scr_wr", rd);
        xfer(1'b0, 16'h0041, 8'h00, "scr_rd", rd);
        chk("scr_val", rd, 8'h5A);
        xfer(1'b1, 16'h0042, 8'h3C, "ctrl_wr", rd);
        chk("ctrl_o_3c", ctrl_o, 8'h3C);
        xfer(1'b0, 16'h0042, 8'h00, "ctrl_rd", rd);
        chk("ctrl_val", rd, 8'h3C);

        // Event counter saturation, then a clear that coincides with an event.
        evt_i = 1'b1;
        repeat (300) tick(1'b0);
        xfer(1'b0, 16'h0043, 8'h00, "evt_sat", rd);
        chk("evt_sat_val", rd, 8'hFF);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 16'h0043; bus.wb_dat_i = 8'h99;
        tick(1'b1);
        chk("evt_clr_ack", bus.wb_ack_o, 1);
        evt_i = 1'b0;
        bus_idle();
        tick(1'b0);
        chk("evt_clr_ackfall", bus.wb_ack_o, 0);
        xfer(1'b0, 16'h0043, 8'h00, "evt_one", rd);
        chk("evt_one_val", rd, 8'h01);

        // Uptime: clear, then snapshot read taken 301 edges later.
        xfer(1'b1, 16'h0044, 8'hEE, "up_clr", rd);
        repeat (299) tick(1'b0);
        xfer(1'b0, 16'h0044, 8'h00, "up0", rd);
        chk("up0_val", rd, 8'h2C);
        repeat (20) tick(1'b0);
        xfer(1'b0, 16'h0045, 8'h00, "up1", rd);
        chk("up1_val", rd, 8'h01);
        xfer(1'b0, 16'h0046, 8'h00, "up2", rd);
        chk("up2_val", rd, 8'h00);
        xfer(1'b0, 16'h0047, 8'h00, "up3", rd);
        chk("up3_val", rd, 8'h00);

        // Miss outside the window and stb without cyc: never acked, no side effect.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 16'h0051; bus.wb_dat_i = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            chk("miss_noack", bus.wb_ack_o, 0);
        end
        bus_idle();
        tick(1'b0);
        xfer(1'b0, 16'h004F, 8'h00, "rsvd", rd);
        chk("rsvd_val", rd, 8'h00);
        bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 16'h0041; bus.wb_dat_i = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("nocyc_noack", bus.wb_ack_o, 0);
        end
        bus_idle();
        tick(1'b0);
        xfer(1'b0, 16'h0041, 8'h00, "scr_keep", rd);
        chk("scr_keep_val", rd, 8'h5A);

        // Reset on the first strobed cycle of a write discards it.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 16'h0041; bus.wb_dat_i = 8'h77;
        rst = 1'b1;
        tick(1'b0);
        chk("rstx_ack", bus.wb_ack_o, 0);
        rst = 1'b0;
        bus_idle();
        tick(1'b0);
        chk("rstx_ack2", bus.wb_ack_o, 0);
        chk("rstx_ctrl", ctrl_o, 8'h00);
        xfer(1'b0, 16'h0041, 8'h00, "rstx_scr", rd);
        chk("rstx_scr_val", rd, 8'h00);

        // Randomized traffic against the model.
        evt_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) tick(1'b0);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                a = 16'($urandom);
                if (a[15:4] == 12'h004) a[15] = 1'b1;
                bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
                bus.wb_we_i = 1'($urandom_range(0, 1));
                bus.wb_adr_i = a; bus.wb_dat_i = 8'($urandom);
                repeat ($urandom_range(1, 3)) begin
                    tick(1'b0);
                    chk("rnd_miss_noack", bus.wb_ack_o, 0);
                end
                bus_idle();
            end else if (kind == 1) begin
                bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b1;
                bus.wb_we_i = 1'b1;
                bus.wb_adr_i = 16'h0040 | 16'($urandom_range(0, 15));
                bus.wb_dat_i = 8'($urandom);
                tick(1'b0);
                chk("rnd_nocyc_noack", bus.wb_ack_o, 0);
                bus_idle();
            end else begin
                a = 16'h0040 | 16'(kind >= 6 ? $urandom_range(4, 7) : $urandom_range(0, 15));
                xfer(($urandom_range(0, 3) == 0), a, 8'($urandom), "rnd", rd);
            end
        end
        evt_rand = 1'b0;
        evt_i = 1'b0;
        tick(1'b0);
        chk("final_ctrl", ctrl_o, m_ctrl);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
